// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by both the RX and TX byte buffers.
package uart_pkg;

  typedef logic [7:0] byte_t;

  localparam int UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Byte storage for the RX FIFO.
// Synchronous write, asynchronous read, no reset.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic [AW-1:0] raddr,
  output byte_t         rdata
);

  byte_t mem_q [DEPTH];

  // capture the pushed byte; contents are never reset
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// RX byte FIFO behind uart_rx, FWFT valid/ready output.
// Optional almost_full port: UART_RX_FIFO_WATERMARK_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = UART_FIFO_DEPTH,
  parameter int ALMOST_FULL = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  byte_t                  in_data,
  input  logic                   in_valid,
  output byte_t                  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_overflow
`ifdef UART_RX_FIFO_WATERMARK_EN
  ,
  output logic                   almost_full
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam bit CfgOk =
    (DEPTH >= 2) &&
    ((DEPTH & (DEPTH - 1)) == 0) &&
    (ALMOST_FULL >= 1) &&
    (ALMOST_FULL <= DEPTH);

  if (!CfgOk) begin : g_bad_cfg
    $error("uart_rx_fifo: bad DEPTH/ALMOST_FULL");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;

  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

  // next pointers, fill level and sticky drop flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop)              ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;
  end

  // pointer, count and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;

`ifdef UART_RX_FIFO_WATERMARK_EN
  logic af_q, af_d;

  assign af_d = (count_d >= CW'(ALMOST_FULL));

  // watermark tracks the same edge as count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) af_q <= 1'b0;
    else        af_q <= af_d;
  end

  assign almost_full = af_q;
`endif

endmodule
